mac_dot_acc: RTL
================

Name: mac_dot_acc

Overview:
- Parametrised successor to the single-lane multiply-accumulator: LANES parallel N-bit multipliers reduced by an adder tree into one wide accumulator.
- Produces one dot-product result per job of cfg_len input beats, with valid/ready handshakes on both sides.
- Sits between operand-fetch logic and result writeback in the accelerator datapath.

Parameters:
- N, 16, operand width per lane.
- LANES, 4, number of parallel multiply lanes; power of two, at least 1.
- LEN_W, 8, width of cfg_len; a job is at most 2^LEN_W-1 beats.
- ACC_W, 2*N+LEN_W+$clog2(LANES), accumulator width. The default cannot overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- cfg_len  in  LEN_W  beats per job; sampled on the first accepted beat of a job.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat.
- in_a  in  LANES*N  lane operands A; lane i is bits [i*N +: N].
- in_b  in  LANES*N  lane operands B, same packing.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_acc  out  ACC_W  accumulated dot product.
- busy  out  1  job in progress; high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a clock edge) clears all state:
  - state=IDLE, all pipeline valids and accumulator are 0.
  - out_valid=0, out_acc=0, busy=0.
  - in_ready=0 while rst=0.
- Beat accept: a beat is accepted when in_valid && in_ready.
- Pipeline stages:
  - P1: register the LANES products, each 2N wide, with a valid bit.
  - P2: register the lane sum, extended to ACC_W, with a valid bit.
  - ACC stage: when the P2 valid is set, acc <= (first beat of job ? 0 : acc) + sum.
- Arithmetic is unsigned by default. Results wrap modulo 2^ACC_W; no saturation.
- FSM states:
  - IDLE: in_ready=1. The first accepted beat latches cfg_len. cfg_len=0 is treated as 1. Beat count is set to 1. Go to ACC, or straight to DRAIN if the latched length is 1.
  - ACC: in_ready=1. Each accepted beat increments the count. Cycles with in_valid=0 insert pipeline bubbles; these do not change acc. On the accepted beat where count reaches the length, go to DRAIN.
  - DRAIN: in_ready=0. Wait until the last beat has left the ACC stage, i.e. all pipeline valids are clear and the final add is done. Then go to HOLD.
  - HOLD: out_valid=1, out_acc=acc. Both are held stable while out_ready=0. On out_valid && out_ready, go to IDLE.
- Latency:
  - Last beat accepted at edge t → acc final at edge t+3 → out_valid high from edge t+4 (4 cycles).
  - Minimum job period is cfg_len+5 cycles.
- Handshake rules:
  - in_ready is registered.
  - in_ready is never asserted in DRAIN or HOLD, so jobs never overlap.
  - in_a/in_b are ignored when the beat is not accepted.
- Boundary conditions:
  - Changes to cfg_len mid-job are ignored.
  - out_ready with out_valid=0 has no effect.
  - Reset mid-job discards the partial sum with no output. The next job starts clean.

Optional Feature:
- Macro: MAC_DOT_ACC_SIGNED_EN.
- Defined: in_a/in_b lanes are two's-complement. Products and the lane sum are sign-extended to ACC_W, and out_acc is two's-complement.
- Undefined: all operands are unsigned and zero-extended.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs → out_valid=0, out_acc=0, busy=0, in_ready=0. After release: in_ready=1, busy=0.
- Single beat: cfg_len=1, in_a lanes {1,2,3,4}, in_b lanes {5,6,7,8} → out_valid rises 4 cycles after accept with out_acc=70. in_ready=0 until the result is taken.
- Max operands: cfg_len=3, all lanes 0xFFFF × 0xFFFF, back-to-back → out_acc=0xBFFE8000C, no wrap. Job period is 8 cycles.
- Bubbles and backpressure:
  - cfg_len=2, beats {1,1,1,1}·{2,2,2,2} separated by 3 idle cycles → out_acc=16.
  - Hold out_ready=0 for 5 cycles → out_valid and out_acc stay stable and in_ready stays 0.
  - Release out_ready → in_ready=1 the following cycle.
- Reset mid-job: cfg_len=4, reset after 2 beats, then a new job with cfg_len=1, lanes {2,0,0,0}·{3,0,0,0} → out_acc=6, no stale contribution.
- Signed build (MAC_DOT_ACC_SIGNED_EN): cfg_len=1, lanes in_a {0xFFFE,1,0,0}, in_b {3,3,0,0} → out_acc = -3 as an ACC_W-bit two's-complement value (all ones except bit 1 clear for the low 2 bits: ...FFD). Unsigned build with the same stimulus → out_acc=0x2FFFD.

Source files
------------

// File: rtl/mac_dot_acc.sv
// mac_dot_acc: LANES-wide dot-product engine. LANES parallel N-bit multipliers
// feed an adder tree into one ACC_W-bit accumulator; one result per job of
// cfg_len beats, with valid/ready handshakes on input and output.
//
// Pipeline: operand register -> lane products (P1) -> lane sum (P2) -> acc.
// Last beat accepted at edge t: acc final at t+3, out_valid high from t+4.
//
// Build option: define MAC_DOT_ACC_SIGNED_EN for two's-complement lane
// operands (products and lane sum sign-extended). Default build is unsigned.
module mac_dot_acc #(
    parameter int N     = 16,
    parameter int LANES = 4,
    parameter int LEN_W = 8,
    parameter int ACC_W = 2*N + LEN_W + $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*N-1:0] in_a,
    input  logic [LANES*N-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

`ifdef MAC_DOT_ACC_SIGNED_EN
    localparam logic SIGNED_OPS = 1'b1;
`else
    localparam logic SIGNED_OPS = 1'b0;
`endif
    localparam int EXT_W = ACC_W - 2*N;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   cnt_inc;
    logic               beat_ok;
    logic               pipe_empty;

    logic               p0_valid, p1_valid, p2_valid;
    logic               p0_first, p1_first, p2_first;
    logic [LANES*N-1:0] a_q, b_q;
    logic [2*N-1:0]     prod_next [LANES];
    logic [2*N-1:0]     p1_prod   [LANES];
    logic [ACC_W-1:0]   lane_sum;
    logic [ACC_W-1:0]   p2_sum;
    logic [ACC_W-1:0]   acc_q;

    assign beat_ok    = in_valid & in_ready;
    // A zero length is treated as a single-beat job.
    assign eff_len    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign cnt_inc    = cnt_q + LEN_W'(1);
    assign pipe_empty = ~(p0_valid | p1_valid | p2_valid);

    // Lane products: operands extended to 2N bits (zero or sign) before the
    // multiply, so the low 2N bits are the exact product in either build.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_next[l] = {{N{SIGNED_OPS & a_q[l*N+N-1]}}, a_q[l*N +: N]}
                         * {{N{SIGNED_OPS & b_q[l*N+N-1]}}, b_q[l*N +: N]};
        end
    end

    // Adder tree over the registered lane products, extended to ACC_W.
    always_comb begin
        // NOTE: default assignment first, so every path drives lane_sum and no latch is inferred.
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + {{EXT_W{SIGNED_OPS & p1_prod[l][2*N-1]}}, p1_prod[l]};
        end
    end

    // Datapath registers: operands, products and lane sum, qualified by the valid bits.
    // NOTE: these data registers take no reset; only the valid bits decide what is consumed.
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            a_q <= in_a;
            b_q <= in_b;
        end
        p1_prod <= prod_next;
        p2_sum  <= lane_sum;
    end

    // Pipeline valid/first-beat tracking and the accumulator stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            p0_valid <= 1'b0;
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            p0_first <= 1'b0;
            p1_first <= 1'b0;
            p2_first <= 1'b0;
            acc_q    <= '0;
        end else begin
            p0_valid <= beat_ok;
            p0_first <= beat_ok && (state == IDLE);
            p1_valid <= p0_valid;
            p1_first <= p0_first;
            p2_valid <= p1_valid;
            p2_first <= p1_first;
            if (p2_valid) begin
                acc_q <= (p2_first ? '0 : acc_q) + p2_sum;
            end
        end
    end

    // Job control FSM with registered in_ready, out_valid, out_acc and busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            busy      <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (beat_ok) begin
                        len_q <= eff_len;
                        cnt_q <= LEN_W'(1);
                        busy  <= 1'b1;
                        if (eff_len == LEN_W'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat_ok) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Final add has landed once no beat remains anywhere in the pipe.
                    if (pipe_empty) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_acc   <= acc_q;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
